alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Shares the single 16-bit execution ALU between two requesters: the decode stage (port 0) and the debug/test port (port 1). Arbitrates round-robin with a valid/ready handshake, drives the ALU operand and opcode inputs from registers, and waits a fixed ALU latency. It then captures ans_ex, data_out, DM_data and flag_ex into a tagged response register held until accepted. Reserved opcodes are rejected without touching the ALU.

Parameters:
W, 16, datapath width (A, B, data_in, results)
OPW, 6, opcode width (op_dec)
ALU_LAT, 1, clock edges from operand/opcode registers changing to ALU outputs valid; legal 1..7
RSV_MASK, 32'h000C_0808, bit n set = opcode n reserved (3, 11, 18, 19); opcodes 32..63 always reserved

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OPW  opcode
req0_a  in  W  operand A
req0_b  in  W  operand B
req0_din  in  W  data_in operand
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_din: same as requester 0, for port 1
alu_op  out  OPW  to ALU op_dec
alu_a  out  W  to ALU A
alu_b  out  W  to ALU B
alu_din  out  W  to ALU data_in
alu_ans  in  W  from ALU ans_ex
alu_dout  in  W  from ALU data_out
alu_dm  in  W  from ALU DM_data
alu_flag  in  2  from ALU flag_ex
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the operation
rsp_ans  out  W  captured ans_ex
rsp_dout  out  W  captured data_out
rsp_dm  out  W  captured DM_data
rsp_flag  out  2  captured flag_ex
rsp_err  out  1  opcode was reserved; result fields zero
busy  out  1  state != IDLE
op_count  out  16  completed responses, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; round-robin pointer favours req0; lat_cnt 0.
- States and transitions:
  - IDLE -> EXEC on grant of a legal op.
  - IDLE -> DONE on grant of a reserved op.
  - EXEC -> DONE when lat_cnt reaches ALU_LAT - 1.
  - DONE -> IDLE on rsp_ready.
- Arbitration, IDLE only:
  - Exactly one valid: grant it.
  - Both valid: grant the port not granted last; the pointer updates on every grant.
  - reqN_ready is combinational: high only in IDLE for the granted port, the same cycle as the grant. A transfer occurs when valid and ready are both high.
  - Ready is 0 in EXEC and DONE. Requesters hold valid and payload until accepted.
- Issue on a legal grant:
  - alu_op/a/b/din register the payload at the grant edge. They hold until the next legal grant and are never cleared by completion.
  - lat_cnt clears to 0, then increments once per cycle in EXEC.
- Capture:
  - On the EXEC -> DONE edge, rsp_ans/dout/dm/flag register the ALU outputs.
  - Same edge: rsp_valid = 1, rsp_id = granted port, rsp_err = 0.
  - Minimum grant-to-rsp_valid latency is ALU_LAT + 1 cycles.
- Reserved op:
  - Goes IDLE -> DONE directly, 1 cycle grant-to-rsp_valid.
  - rsp_err = 1, data and flag fields 0.
  - alu_* stay unchanged.
- DONE:
  - All rsp_* stable while rsp_valid && !rsp_ready.
  - On accept: rsp_valid falls next edge, op_count increments, state returns to IDLE. The next grant happens no earlier than the following cycle, so there is no bypass.
- Back-pressure: rsp_ready low indefinitely stalls both requesters. Nothing is dropped.
- Reset mid-operation (EXEC or DONE): aborts immediately and discards the pending response. The requester is not re-notified.
- Changes to reqN_valid or payload while not ready are ignored.
- rsp_err_count is not provided; errors are counted in op_count.

Decomposition:
- Shared package alu_pkg: OPW, W, opcode localparams (ADD=6'd0 ... 6'd31), RSV_MASK, state encoding (IDLE, EXEC, DONE; 2-bit).
- One sub-module: rr_arb2, a 2-way round-robin arbiter with pointer register, valid[1:0] -> grant[1:0]. It is reused elsewhere.
- Everything else is in alu_issue_ctrl.

Test Plan:
- Single legal op: req0 op=6'd0, a=16'h4000, b=16'hC000, din=16'h0008, ALU model ans=a+b. Required: req0_ready same cycle; rsp_valid exactly ALU_LAT+1 cycles later; rsp_ans=16'h0000, rsp_id=0, rsp_err=0; op_count=1 after accept.
- Contention: req0 and req1 valid every cycle, rsp_ready=1. Required: grants alternate 0,1,0,1 starting with 0 after reset; 8 responses carry rsp_id 0,1,0,1,...
- Reserved opcodes 3, 11, 18, 19 and 40 from req1. Required: rsp_err=1 one cycle after grant; data fields 0; alu_op unchanged from the prior legal op (6'd0).
- Back-pressure: rsp_ready=0 for 20 cycles after rsp_valid. Required: rsp_* stable; req0_ready and req1_ready stay 0; busy=1; on rsp_ready=1, single acceptance, op_count +1.
- Reset mid-EXEC, with ALU_LAT=4 and reset low at lat_cnt=2. Required: all outputs 0 asynchronously; no rsp_valid after reset release; first subsequent grant goes to req0.
- Wrap: preload op_count to 16'hFFFF via 65535 accepted reserved ops (forced in sim). Required: next accept gives op_count=16'h0000.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths, opcode constants, reserved-opcode mask and the
//               issue-controller state encoding for the ALU sharing logic.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int W   = 16;
    localparam int OPW = 6;

    // bit n set = opcode n reserved; opcodes 32..63 are reserved regardless
    localparam logic [31:0] RSV_MASK = 32'h000C_0808;

    localparam logic [OPW-1:0] c_op_add  = 6'd0;
    localparam logic [OPW-1:0] c_op_last = 6'd31;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_exec = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    function automatic logic is_reserved(input logic [OPW-1:0] op);
        return (|op[OPW-1:5]) | RSV_MASK[op[4:0]];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_if
// Description : Requester, ALU and response bundle around the issue controller.
//               master = environment side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic [W-1:0]   req0_din;

    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic [W-1:0]   req1_din;

    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_din;
    logic [W-1:0]   alu_ans;
    logic [W-1:0]   alu_dout;
    logic [W-1:0]   alu_dm;
    logic [1:0]     alu_flag;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_ans;
    logic [W-1:0]   rsp_dout;
    logic [W-1:0]   rsp_dm;
    logic [1:0]     rsp_flag;
    logic           rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_din,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_din,
        input  req1_ready,
        input  alu_op, alu_a, alu_b, alu_din,
        output alu_ans, alu_dout, alu_dm, alu_flag,
        input  rsp_valid, rsp_id, rsp_ans, rsp_dout, rsp_dm, rsp_flag, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_din,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_din,
        output req1_ready,
        output alu_op, alu_a, alu_b, alu_din,
        input  alu_ans, alu_dout, alu_dm, alu_flag,
        output rsp_valid, rsp_id, rsp_ans, rsp_dout, rsp_dm, rsp_flag, rsp_err,
        input  rsp_ready
    );

endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; on contention the port not
//               granted last wins. Pointer resets to favour port 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic r_last;   // 1 = port 1 was granted last

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (|o_grant) begin
            r_last <= o_grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Shares one ALU between decode (port 0) and debug (port 1);
//               issues, waits ALU_LAT edges and holds a tagged response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    alu_issue_ctrl_if.slave bus,
    output logic            busy,
    output logic [15:0]     op_count
);

    localparam logic [2:0] c_lat_last = 3'(ALU_LAT - 1);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [2:0]     r_lat_cnt;
    logic [1:0]     w_valid;
    logic [1:0]     w_grant;
    logic           w_arb_en;
    logic           w_take;
    logic           w_gid;
    logic           w_rsv;
    logic           w_lat_done;
    logic           w_accept;
    logic [OPW-1:0] w_g_op;
    logic [W-1:0]   w_g_a;
    logic [W-1:0]   w_g_b;
    logic [W-1:0]   w_g_din;

    logic           r_gid;
    logic [OPW-1:0] r_alu_op;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [W-1:0]   r_alu_din;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic           r_rsp_err;
    logic [W-1:0]   r_rsp_ans;
    logic [W-1:0]   r_rsp_dout;
    logic [W-1:0]   r_rsp_dm;
    logic [1:0]     r_rsp_flag;
    logic [15:0]    r_op_count;

    // Gating with reset keeps ready low while reset is asserted
    assign w_valid  = {bus.req1_valid, bus.req0_valid};
    assign w_arb_en = reset && (r_state == c_idle);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_arb_en),
        .i_valid (w_valid),
        .o_grant (w_grant)
    );

    assign w_take     = |w_grant;
    assign w_gid      = w_grant[1];
    assign w_g_op     = w_gid ? bus.req1_op  : bus.req0_op;
    assign w_g_a      = w_gid ? bus.req1_a   : bus.req0_a;
    assign w_g_b      = w_gid ? bus.req1_b   : bus.req0_b;
    assign w_g_din    = w_gid ? bus.req1_din : bus.req0_din;
    assign w_rsv      = is_reserved(w_g_op);
    assign w_lat_done = (r_state == c_exec) && (r_lat_cnt == c_lat_last);
    assign w_accept   = (r_state == c_done) && bus.rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_take)     w_state_nxt = w_rsv ? c_done : c_exec;
            c_exec:  if (w_lat_done) w_state_nxt = c_done;
            c_done:  if (w_accept)   w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        bus.req0_ready = w_grant[0];
        bus.req1_ready = w_grant[1];
        busy           = (r_state != c_idle);
    end

    // ALU operand registers only move on a legal grant; completion never clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_op  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_din <= '0;
            r_gid     <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            if (w_take) begin
                r_gid     <= w_gid;
                r_lat_cnt <= '0;
                if (!w_rsv) begin
                    r_alu_op  <= w_g_op;
                    r_alu_a   <= w_g_a;
                    r_alu_b   <= w_g_b;
                    r_alu_din <= w_g_din;
                end
            end else if (r_state == c_exec) begin
                r_lat_cnt <= r_lat_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_ans   <= '0;
            r_rsp_dout  <= '0;
            r_rsp_dm    <= '0;
            r_rsp_flag  <= '0;
            r_op_count  <= '0;
        end else begin
            if (w_take && w_rsv) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= w_gid;
                r_rsp_err   <= 1'b1;
                r_rsp_ans   <= '0;
                r_rsp_dout  <= '0;
                r_rsp_dm    <= '0;
                r_rsp_flag  <= '0;
            end else if (w_lat_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_gid;
                r_rsp_err   <= 1'b0;
                r_rsp_ans   <= bus.alu_ans;
                r_rsp_dout  <= bus.alu_dout;
                r_rsp_dm    <= bus.alu_dm;
                r_rsp_flag  <= bus.alu_flag;
            end else if (w_accept) begin
                r_rsp_valid <= 1'b0;
                r_op_count  <= r_op_count + 16'd1;
            end
        end
    end

    assign bus.alu_op    = r_alu_op;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_din   = r_alu_din;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_ans   = r_rsp_ans;
    assign bus.rsp_dout  = r_rsp_dout;
    assign bus.rsp_dm    = r_rsp_dm;
    assign bus.rsp_flag  = r_rsp_flag;
    assign op_count      = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a transaction-level
//               reference model and a latency-aware ALU stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // ALU stub: results only become meaningful LAT edges after operands settle
    function automatic logic [49:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] din);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {s[15:0], a ^ din, b - din, s[16], (s[15:0] == 16'h0)};
    endfunction

    int unsigned alu_age = 0;
    logic [53:0] alu_prev = '0;
    always @(negedge clk) begin
        if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_din} != alu_prev) begin
            alu_prev = {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_din};
            alu_age  = 0;
        end else if (alu_age < 1000) begin
            alu_age++;
        end
    end
    assign {bus.alu_ans, bus.alu_dout, bus.alu_dm, bus.alu_flag} =
        (alu_age + 1 >= LAT) ? alu_fn(bus.alu_a, bus.alu_b, bus.alu_din)
                             : {16'hDEAD, 16'hBEEF, 16'hF00D, 2'b10};

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transaction-level model: one op in flight, response due at a known cycle
    bit          m_busy;
    bit          m_last;
    int unsigned m_due;
    logic        m_id, m_err;
    logic [49:0] m_res;
    logic [5:0]  m_aop;
    logic [15:0] m_aa, m_ab, m_adin;
    logic [15:0] m_count;
    logic [1:0]  last_gnt;
    bit          last_acc;

    function automatic bit op_reserved(input logic [5:0] op);
        return (op >= 6'd32) || (op inside {6'd3, 6'd11, 6'd18, 6'd19});
    endfunction

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_due = 0; m_id = 0; m_err = 0; m_res = '0;
        m_aop = '0; m_aa = '0; m_ab = '0; m_adin = '0; m_count = '0;
        last_gnt = '0; last_acc = 0;
    endtask

    task automatic evaluate();
        logic [1:0]  vld, exp_rdy;
        bit          rv_exp;
        logic [5:0]  op;
        logic [15:0] a, b, din;
        cyc++;
        last_gnt = '0;
        last_acc = 0;
        vld = {bus.req1_valid, bus.req0_valid};
        exp_rdy = 2'b00;
        if (!m_busy) exp_rdy = (vld == 2'b11) ? (m_last ? 2'b01 : 2'b10) : vld;
        rv_exp = m_busy && (cyc >= m_due);
        check("ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);
        check("busy", busy, m_busy);
        check("op_count", op_count, m_count);
        check("alu_regs", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_din}, {m_aop, m_aa, m_ab, m_adin});
        check("rsp_valid", bus.rsp_valid, rv_exp);
        if (rv_exp)
            check("rsp_fields",
                  {bus.rsp_id, bus.rsp_err, bus.rsp_ans, bus.rsp_dout, bus.rsp_dm, bus.rsp_flag},
                  {m_id, m_err, m_res});
        if (rv_exp && bus.rsp_ready) begin
            m_busy = 0;
            m_count++;
            last_acc = 1;
        end else if (exp_rdy != 2'b00) begin
            last_gnt = exp_rdy;
            m_id   = exp_rdy[1];
            op     = m_id ? bus.req1_op  : bus.req0_op;
            a      = m_id ? bus.req1_a   : bus.req0_a;
            b      = m_id ? bus.req1_b   : bus.req0_b;
            din    = m_id ? bus.req1_din : bus.req0_din;
            m_busy = 1;
            m_last = m_id;
            if (op_reserved(op)) begin
                m_err = 1; m_res = '0; m_due = cyc + 1;
            end else begin
                m_err = 0; m_res = alu_fn(a, b, din); m_due = cyc + LAT + 1;
                m_aop = op; m_aa = a; m_ab = b; m_adin = din;
            end
        end
    endtask

    // Inputs for the current cycle are driven at the negedge before calling step
    task automatic step();
        #1 evaluate();
        @(negedge clk);
    endtask

    function automatic logic [5:0] pick_op(input int unsigned pct_rsv);
        int unsigned v;
        if ($urandom_range(99) < pct_rsv) begin
            if ($urandom_range(1) == 1) v = $urandom_range(63, 32);
            else case ($urandom_range(3))
                0:       v = 3;
                1:       v = 11;
                2:       v = 18;
                default: v = 19;
            endcase
        end else begin
            do v = $urandom_range(31); while (v inside {3, 11, 18, 19});
        end
        return 6'(v);
    endfunction

    task automatic set_req(input int p, input logic v, input logic [5:0] op,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] din);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_din = din;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_din = din;
        end
    endtask

    task automatic rand_req(input int p, input logic v, input int unsigned pct_rsv);
        set_req(p, v, pick_op(pct_rsv), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_grant(input int p);
        for (int i = 0; i < 60; i++) begin
            step();
            if (last_gnt[p]) break;
        end
        check($sformatf("grant%0d_wait", p), last_gnt[p], 1'b1);
    endtask

    task automatic wait_acc();
        for (int i = 0; i < 100; i++) begin
            step();
            if (last_acc) break;
        end
        check("accept_wait", last_acc, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && m_busy; i++) step();
        check("idle_wait", m_busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {bus.req1_ready, bus.req0_ready, busy, op_count, bus.rsp_valid,
                              bus.rsp_id, bus.rsp_err, bus.rsp_flag}, '0);
        check({tag, "_alu"}, {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_din}, '0);
        check({tag, "_rsp"}, {bus.rsp_ans, bus.rsp_dout, bus.rsp_dm}, '0);
    endtask

    initial begin
        int unsigned acc;
        logic [5:0] rsv_ops [5];
        rsv_ops = '{6'd3, 6'd11, 6'd18, 6'd19, 6'd40};
        model_reset();
        set_req(0, 0, '0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0, '0);
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Contention: both requesters always valid
        bus.rsp_ready = 1'b1;
        rand_req(0, 1, 0);
        rand_req(1, 1, 0);
        acc = 0;
        for (int i = 0; i < 200 && acc < 8; i++) begin
            step();
            if (last_acc) acc++;
            if (last_gnt[0]) rand_req(0, 1, 0);
            if (last_gnt[1]) rand_req(1, 1, 0);
        end
        check("contention_rsps", acc, 8);
        set_req(0, 0, '0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0, '0);
        wait_idle();

        // Single legal op whose sum wraps to zero
        set_req(0, 1, 6'd0, 16'h4000, 16'hC000, 16'h0008);
        wait_grant(0);
        set_req(0, 0, '0, '0, '0, '0);
        wait_acc();
        step();

        // Reserved opcodes from port 1
        foreach (rsv_ops[k]) begin
            set_req(1, 1, rsv_ops[k], 16'($urandom), 16'($urandom), 16'($urandom));
            wait_grant(1);
            set_req(1, 0, '0, '0, '0, '0);
            wait_acc();
        end
        step();
        check("alu_op_after_rsv", bus.alu_op, 6'd0);

        // Back-pressure with both requesters waiting
        bus.rsp_ready = 1'b0;
        rand_req(0, 1, 0);
        rand_req(1, 1, 0);
        wait_grant(0);
        set_req(0, 0, '0, '0, '0, '0);
        repeat (LAT + 21) step();
        bus.rsp_ready = 1'b1;
        wait_acc();
        wait_grant(1);
        set_req(1, 0, '0, '0, '0, '0);
        wait_idle();

        // Randomized traffic with back-pressure and reserved ops
        for (int i = 0; i < 800; i++) begin
            if (!bus.req0_valid || last_gnt[0]) rand_req(0, ($urandom_range(99) < 60), 25);
            if (!bus.req1_valid || last_gnt[1]) rand_req(1, ($urandom_range(99) < 60), 25);
            bus.rsp_ready = ($urandom_range(99) < 70);
            step();
        end
        set_req(0, 0, '0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0, '0);
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Reset while the counter is at 2 in EXEC
        bus.rsp_ready = 1'b0;
        set_req(0, 1, 6'd0, 16'h1234, 16'h1111, 16'h0001);
        wait_grant(0);
        rand_req(1, 1, 0);
        step();
        step();
        reset = 1'b0;
        #1 check_all_zero("reset_exec");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        wait_grant(0);
        set_req(0, 0, '0, '0, '0, '0);
        wait_grant(1);
        set_req(1, 0, '0, '0, '0, '0);
        wait_idle();

        // Counter wrap
        force dut.r_op_count = 16'hFFFE;
        #1 release dut.r_op_count;
        m_count = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            set_req(1, 1, 6'd40, 16'($urandom), 16'($urandom), 16'($urandom));
            wait_grant(1);
            set_req(1, 0, '0, '0, '0, '0);
            wait_acc();
            if (k == 1) begin
                step();
                check("wrap_zero", op_count, 16'h0000);
            end
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
